simd_alu_pipe: RTL and testbench
================================

Name: simd_alu_pipe

Overview:
- Parametrised, pipelined SIMD vector ALU for the SIMD processor datapath; successor to the single-lane 32-bit ALU.
- Applies one opcode across LANES independent signed lanes of DATA_W bits.
- Adds a cross-lane dot-product reduction with a persistent accumulator.
- Sits between the vector register read stage and the writeback stage, with valid/ready handshakes on both sides and a fixed 2-cycle latency when not stalled.

Parameters:
- LANES, 4, number of parallel lanes (>=1, power of two).
- DATA_W, 16, lane width in bits, signed two's complement (2..32).
- ACC_W, 48, accumulator width in bits (>= 2*DATA_W + log2(LANES)).
- OPCODE_WIDTH, 3, opcode field width.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- opcode  in  OPCODE_WIDTH  operation for this beat.
- a  in  LANES*DATA_W  operand A; lane i is a[i*DATA_W +: DATA_W].
- b  in  LANES*DATA_W  operand B, same packing as a.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANES*DATA_W  per-lane result.
- out_acc  out  ACC_W  accumulator value after this beat.
- out_opcode  out  OPCODE_WIDTH  opcode carried with the result.

Behaviour:
- Opcodes:
  - 0 NOOP
  - 1 ADD
  - 2 SUB
  - 3 MUL
  - 4 DOTP
  - 5 ACC_CLR
  - 6 ACC_RD
  - 7 reserved; executes as NOOP but is still carried through as 7.
- Pipeline: two registered stages, S1 and S2. Global advance is en = !out_valid || out_ready; in_ready = en. A beat is accepted when in_valid && in_ready.
- Latency: a beat accepted in cycle N presents out_valid in cycle N+2 if not stalled. Throughput is 1 beat/cycle. On stall, all stages hold and out_* stay stable until accepted.
- S1, per lane:
  - ADD: a+b.
  - SUB: a-b.
  - MUL and DOTP: full signed 2*DATA_W product.
- S2:
  - ADD/SUB: out_data lane = low DATA_W bits (wrap).
  - MUL: out_data lane = low DATA_W bits of the product.
  - DOTP: sum of all lane products, sign-extended to ACC_W, added to the accumulator. The accumulator updates when the beat leaves S2 into the output register. out_data lane0 = low DATA_W bits of the new accumulator; other lanes 0.
  - ACC_CLR: accumulator <= 0; out_data = 0.
  - ACC_RD: out_data lane0 = acc[DATA_W-1:0]; other lanes 0; accumulator unchanged.
  - NOOP/reserved: out_data = 0.
- out_acc always reflects the accumulator value after the beat's own effect.
- The accumulator wraps modulo 2^ACC_W.
- Back-to-back DOTPs accumulate correctly with no bubbles; the accumulator forwards internally.
- Every output beat produces out_valid, including NOOP.
- Reset (async assert, sync deassert internal):
  - All valids 0.
  - Accumulator 0.
  - out_data 0, out_acc 0, out_opcode 0.
  - in_ready = 1 after reset.
  - Reset mid-operation discards in-flight beats; no out_valid is produced for them.
- A simultaneous accept and stall cannot occur, because in_ready is de-asserted whenever S2 holds.
- out_ready may be high with out_valid low; this has no effect.

Optional Feature:
- SIMD_ALU_SAT_EN
- When defined:
  - ADD/SUB/MUL lane results saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] instead of wrapping.
  - The accumulator saturates to signed ACC_W limits.
  - The added output port sat_flag (LANES+1 bits) flags per-lane saturation in bits [LANES-1:0] and accumulator saturation in bit LANES, aligned with out_valid.
- When undefined: all arithmetic wraps, and the sat_flag port is absent.

Test Plan:
All scenarios use LANES=4, DATA_W=16, ACC_W=48.
1. ADD with a lanes={1,-2,32767,0}, b={1,3,1,5}, out_ready=1 -> out_valid 2 cycles later; out_data={2,1,-32768,5} (wrap). With SIMD_ALU_SAT_EN: lane2=32767 and sat_flag[2]=1.
2. SUB then MUL back-to-back, a={300,-7,2,0}, b={100,7,-3,9} -> out_data={200,-14,5,-9} then {30000,-49,-6,0} on consecutive cycles.
3. ACC_CLR, then DOTP a={1,2,3,4}, b={5,6,7,8}, then DOTP again -> out_acc 0, 70, 140; out_data lane0 70, then 140; lanes 1..3 = 0.
4. Backpressure: stream 4 ADD beats with out_ready held low for 3 cycles -> in_ready drops after the pipeline fills; out_data stays stable; all 4 results emerge in order with none lost or duplicated.
5. Reset mid-stream: assert rstn=0 with 2 DOTP beats in flight -> out_valid=0 and out_acc=0 immediately. A following ACC_RD returns 0.
6. Opcode 7 with arbitrary operands -> out_data=0, out_opcode=7, accumulator unchanged.

Source files
------------

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage SIMD lane ALU with dot-product accumulator; define SIMD_ALU_SAT_EN for saturating arithmetic and the sat_flag port
module simd_alu_pipe #(
    parameter int LANES        = 4,
    parameter int DATA_W       = 16,
    parameter int ACC_W        = 48,
    parameter int OPCODE_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [LANES*DATA_W-1:0]   a,
    input  logic [LANES*DATA_W-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [ACC_W-1:0]          out_acc,
`ifdef SIMD_ALU_SAT_EN
    output logic [OPCODE_WIDTH-1:0]   out_opcode,
    output logic [LANES:0]            sat_flag
`else
    output logic [OPCODE_WIDTH-1:0]   out_opcode
`endif
);
`ifdef SIMD_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam int PW = 2 * DATA_W;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_DOTP = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_CLR  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_RD   = OPCODE_WIDTH'(6);
    localparam logic signed [PW-1:0]    L_MAX   = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0]    L_MIN   = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]        A_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]        A_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]                r_rst_q;
    logic                      w_rst_n;
    logic                      w_en;
    logic signed [PW-1:0]      w_s1_res [LANES];
    logic                      r_s1_valid;
    logic [OPCODE_WIDTH-1:0]   r_s1_op;
    logic signed [PW-1:0]      r_s1_res [LANES];
    logic                      r_out_valid;
    logic [LANES*DATA_W-1:0]   r_out_data;
    logic [ACC_W-1:0]          r_acc;
    logic [OPCODE_WIDTH-1:0]   r_out_op;
    logic signed [ACC_W-1:0]   w_dot;
    logic [ACC_W-1:0]          w_acc_sum;
    logic                      w_acc_sat;
    logic [ACC_W-1:0]          w_acc_next;
    logic                      w_lane_op;
    logic [LANES-1:0]          w_lane_sat;
    logic [LANES*DATA_W-1:0]   w_out_data;

    // reset asserts asynchronously and releases two clocks after rstn rises
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rst_q <= 2'b00;
        else       r_rst_q <= {r_rst_q[0], 1'b1};
    end

    assign w_rst_n  = r_rst_q[1];
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en && w_rst_n;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DATA_W-1:0] w_a, w_b;
        logic signed [PW-1:0]     w_prod;
        assign w_a    = a[i*DATA_W +: DATA_W];
        assign w_b    = b[i*DATA_W +: DATA_W];
        assign w_prod = w_a * w_b;
        assign w_s1_res[i] = (opcode == OP_ADD) ? PW'(w_a) + PW'(w_b) :
                             (opcode == OP_SUB) ? PW'(w_a) - PW'(w_b) :
                             (opcode == OP_MUL || opcode == OP_DOTP) ? w_prod : '0;
    end

    // cross-lane reduction of the S1 products into accumulator width
    always_comb begin
        w_dot = '0;
        for (int k = 0; k < LANES; k++) w_dot = w_dot + ACC_W'(r_s1_res[k]);
    end

    assign w_acc_sum  = r_acc + w_dot;
    assign w_acc_sat  = SAT_EN && (r_s1_op == OP_DOTP) && (r_acc[ACC_W-1] == w_dot[ACC_W-1]) &&
                        (w_acc_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_acc_next = (r_s1_op == OP_DOTP) ? (w_acc_sat ? (r_acc[ACC_W-1] ? A_MIN : A_MAX) : w_acc_sum) :
                        (r_s1_op == OP_CLR)  ? '0 : r_acc;
    assign w_lane_op  = (r_s1_op == OP_ADD) || (r_s1_op == OP_SUB) || (r_s1_op == OP_MUL);

    // per-lane result narrowing, plus lane0 accumulator views for DOTP/ACC_RD
    always_comb begin
        w_out_data = '0;
        w_lane_sat = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w_lane_op) begin
                w_lane_sat[k] = SAT_EN && (r_s1_res[k] > L_MAX || r_s1_res[k] < L_MIN);
                w_out_data[k*DATA_W +: DATA_W] = w_lane_sat[k] ?
                    (r_s1_res[k][PW-1] ? L_MIN[DATA_W-1:0] : L_MAX[DATA_W-1:0]) : r_s1_res[k][DATA_W-1:0];
            end
        end
        if (r_s1_op == OP_DOTP) w_out_data[DATA_W-1:0] = w_acc_next[DATA_W-1:0];
        if (r_s1_op == OP_RD)   w_out_data[DATA_W-1:0] = r_acc[DATA_W-1:0];
    end

    // both stages advance together; the accumulator commits as a beat enters the output register
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            for (int k = 0; k < LANES; k++) r_s1_res[k] <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_acc       <= '0;
            r_out_op    <= '0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            if (in_valid) begin
                r_s1_op  <= opcode;
                r_s1_res <= w_s1_res;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_out_data;
                r_acc      <= w_acc_next;
                r_out_op   <= r_s1_op;
            end
        end
    end

`ifdef SIMD_ALU_SAT_EN
    logic [LANES:0] r_sat;

    // saturation flags travel with the result beat
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                    r_sat <= '0;
        else if (w_en && r_s1_valid)     r_sat <= {w_acc_sat, w_lane_sat};
    end

    assign sat_flag = r_sat;
`else
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_acc    = r_acc;
    assign out_opcode = r_out_op;
endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: directed checks of the SIMD ALU pipeline
module tb_simd_alu_pipe;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  opcode = '0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [47:0] out_acc;
    logic [2:0]  out_opcode;
`ifdef SIMD_ALU_SAT_EN
    logic [4:0]  sat_flag;
`endif
    int errors = 0;
    int checks = 0;

    simd_alu_pipe dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_acc(out_acc),
`ifdef SIMD_ALU_SAT_EN
        .sat_flag(sat_flag),
`endif
        .out_opcode(out_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack(int l0, int l1, int l2, int l3);
        return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [2:0] op, logic [63:0] va, logic [63:0] vb);
        in_valid = v;
        opcode   = op;
        a        = va;
        b        = vb;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_acc", 64'(out_acc), 64'd0);
        chk("rst_op", 64'(out_opcode), 64'd0);
        rstn = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        drive(1, 3'd1, pack(1, -2, 32767, 0), pack(1, 3, 1, 5));
        tick();
        drive(0, 3'd0, '0, '0);
        chk("add_latency", 64'(out_valid), 64'd0);
        tick();
        chk("add_valid", 64'(out_valid), 64'd1);
`ifdef SIMD_ALU_SAT_EN
        chk("add_data", out_data, pack(2, 1, 32767, 5));
        chk("add_sat", 64'(sat_flag), 64'b00100);
`else
        chk("add_data", out_data, pack(2, 1, -32768, 5));
`endif
        chk("add_op", 64'(out_opcode), 64'd1);
        tick();
        chk("add_drain", 64'(out_valid), 64'd0);

        drive(1, 3'd2, pack(300, -7, 2, 0), pack(100, 7, -3, 9));
        tick();
        drive(1, 3'd3, pack(300, -7, 2, 0), pack(100, 7, -3, 9));
        tick();
        drive(0, 3'd0, '0, '0);
        chk("sub_data", out_data, pack(200, -14, 5, -9));
        tick();
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_data", out_data, pack(30000, -49, -6, 0));

        drive(1, 3'd5, '0, '0);
        tick();
        drive(1, 3'd4, pack(1, 2, 3, 4), pack(5, 6, 7, 8));
        tick();
        chk("clr_acc", 64'(out_acc), 64'd0);
        chk("clr_data", out_data, 64'd0);
        tick();
        drive(0, 3'd0, '0, '0);
        chk("dotp1_acc", 64'(out_acc), 64'd70);
        chk("dotp1_data", out_data, pack(70, 0, 0, 0));
        tick();
        chk("dotp2_acc", 64'(out_acc), 64'd140);
        chk("dotp2_data", out_data, pack(140, 0, 0, 0));
        drive(1, 3'd6, '0, '0);
        tick();
        drive(1, 3'd7, pack(9, 9, 9, 9), pack(3, 3, 3, 3));
        tick();
        drive(0, 3'd0, '0, '0);
        chk("rd_data", out_data, pack(140, 0, 0, 0));
        chk("rd_op", 64'(out_opcode), 64'd6);
        tick();
        chk("rsv_data", out_data, 64'd0);
        chk("rsv_op", 64'(out_opcode), 64'd7);
        chk("rsv_acc", 64'(out_acc), 64'd140);
        tick();

        out_ready = 1'b0;
        drive(1, 3'd1, pack(1, 2, 3, 4), pack(10, 10, 10, 10));
        tick();
        drive(1, 3'd1, pack(2, 4, 6, 8), pack(10, 10, 10, 10));
        tick();
        drive(1, 3'd1, pack(3, 6, 9, 12), pack(10, 10, 10, 10));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold0", out_data, pack(11, 12, 13, 14));
        tick();
        chk("bp_hold1", out_data, pack(11, 12, 13, 14));
        tick();
        chk("bp_hold2", out_data, pack(11, 12, 13, 14));
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_beat2", out_data, pack(12, 14, 16, 18));
        drive(1, 3'd1, pack(4, 8, 12, 16), pack(10, 10, 10, 10));
        tick();
        drive(0, 3'd0, '0, '0);
        chk("bp_beat3", out_data, pack(13, 16, 19, 22));
        tick();
        chk("bp_beat4", out_data, pack(14, 18, 22, 26));
        chk("bp_beat4_valid", 64'(out_valid), 64'd1);
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);

        drive(1, 3'd4, pack(1, 2, 3, 4), pack(5, 6, 7, 8));
        tick();
        tick();
        chk("pre_rst_acc", 64'(out_acc), 64'd210);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_acc", 64'(out_acc), 64'd0);
        drive(0, 3'd0, '0, '0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        drive(1, 3'd6, '0, '0);
        tick();
        drive(0, 3'd0, '0, '0);
        tick();
        chk("post_rd_valid", 64'(out_valid), 64'd1);
        chk("post_rd_data", out_data, 64'd0);
        chk("post_rd_acc", 64'(out_acc), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
